// File: rtl/control_sequencer.sv
// Multicycle control unit for the 9-bit processor: captures an instruction in T0,
// then sequences datapath strobes through T1..T3 and clears its own step counter on Done.
module control_sequencer (
    input  logic       MClock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] DIN,
    input  logic       G_nz,
    output logic       IRin,
    output logic [7:0] Rout,
    output logic [7:0] Rin,
    output logic       DINout,
    output logic       Gout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       W_D,
    output logic       Done,
    output logic [1:0] step
);

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_MVNZ, OP_RSVD
    } op_t;

    step_t      state, state_next;
    logic [8:0] ir;
    op_t        op;
    logic [7:0] x_sel, y_sel;

    assign op    = op_t'(ir[8:6]);
    assign x_sel = 8'b1 << ir[5:3];
    assign y_sel = 8'b1 << ir[2:0];
    assign step  = state;

    always_ff @(posedge MClock) begin
        if (Resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == T0 && Run)
                ir <= DIN;
        end
    end

    always_comb begin
        IRin       = 1'b0;
        Rout       = '0;
        Rin        = '0;
        DINout     = 1'b0;
        Gout       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        ADDRin     = 1'b0;
        DOUTin     = 1'b0;
        W_D        = 1'b0;
        Done       = 1'b0;
        state_next = state;

        case (state)
            T0: begin
                IRin = Run;
                if (Run)
                    state_next = T1;
            end
            T1: begin
                state_next = T2;
                case (op)
                    OP_MV:   begin Rout = y_sel; Rin = x_sel; Done = 1'b1; end
                    OP_MVI:  begin DINout = 1'b1; Rin = x_sel; Done = 1'b1; end
                    OP_ADD,
                    OP_SUB:  begin Rout = x_sel; Ain = 1'b1; end
                    OP_LD,
                    OP_ST:   begin Rout = y_sel; ADDRin = 1'b1; end
                    OP_MVNZ: begin
                        if (G_nz) begin
                            Rout = y_sel;
                            Rin  = x_sel;
                        end
                        Done = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                state_next = T3;
                case (op)
                    OP_ADD,
                    OP_SUB: begin Rout = y_sel; Gin = 1'b1; AddSub = ir[6]; end
                    OP_ST:  begin Rout = x_sel; DOUTin = 1'b1; W_D = 1'b1; Done = 1'b1; end
                    default: ;
                endcase
            end
            T3: begin
                state_next = T0;
                case (op)
                    OP_ADD,
                    OP_SUB: begin Gout = 1'b1; Rin = x_sel; Done = 1'b1; end
                    OP_LD:  begin DINout = 1'b1; Rin = x_sel; Done = 1'b1; end
                    default: ;
                endcase
            end
            default: state_next = T0;
        endcase

        // Done is the step clear; every legal path reaches it before T3 wraps
        if (Done)
            state_next = T0;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multicycle control unit for the 9-bit processor datapath.
- Captures an instruction word from DIN when Run is high.
- Steps through timesteps T0..T3 on an internal 2-bit step counter.
- Drives register, ALU, memory-interface and bus-select strobes, then pulses Done.
- Owns its step counter and issues the step-clear itself when an instruction completes. It is the consumer/driver end of the timestep interface.

Parameters:
None. Instruction width is fixed at 9 bits, in the form III XXX YYY (opcode, Rx, Ry). There are 8 registers.

Ports:
MClock  in  1  system clock; all state changes on the rising edge
Resetn  in  1  synchronous reset, active-high; clears the step counter and IR
Run  in  1  start request; sampled in T0 only
DIN  in  9  instruction / immediate / memory-data bus input
G_nz  in  1  G register is non-zero (from datapath), used by mvnz
IRin  out  1  IR capture strobe
Rout  out  8  one-hot register-to-bus select; bit i selects Ri
Rin  out  8  one-hot register load enable
DINout  out  1  DIN-to-bus select
Gout  out  1  G-to-bus select
Ain  out  1  A register load
Gin  out  1  G register load
AddSub  out  1  0 = add, 1 = subtract; valid when Gin = 1
ADDRin  out  1  memory address register load
DOUTin  out  1  memory data-out register load
W_D  out  1  memory write enable
Done  out  1  instruction complete; high for exactly one cycle
step  out  2  current timestep, for debug and verification

Behaviour:
- State: step[1:0] and IR[8:0]. Both are 0 after reset. All outputs are combinational functions of step, IR, Run and G_nz.
- Any output not named for a given step/opcode is 0. Rout and Rin are never multi-hot.
- Reset (Resetn = 1) at an edge forces step = 0 and IR = 0. Reset beats Run and beats an in-flight instruction; there is no partial completion.
- T0 (step = 0):
  - IRin = Run.
  - If Run = 1: IR <= DIN and step <= 1.
  - Otherwise hold in T0. No other outputs are asserted in T0.
- Step advance: step <= step + 1 each cycle, except step <= 0 on any cycle with Done = 1. Done is the step clear, so step never wraps through 3 -> 0 other than via Done.
- T1/T2/T3 per opcode. X = IR[5:3], Y = IR[2:0]:
  - 000 mv: T1: Rout[Y], Rin[X], Done.
  - 001 mvi: T1: DINout, Rin[X], Done. The immediate is on DIN during T1.
  - 010 add / 011 sub:
    - T1: Rout[X], Ain.
    - T2: Rout[Y], Gin, AddSub = IR[6].
    - T3: Gout, Rin[X], Done.
  - 100 ld:
    - T1: Rout[Y], ADDRin.
    - T2: no strobes (memory read latency).
    - T3: DINout, Rin[X], Done.
  - 101 st:
    - T1: Rout[Y], ADDRin.
    - T2: Rout[X], DOUTin, W_D, Done.
  - 110 mvnz: T1: if G_nz then Rout[Y] and Rin[X]; Done is asserted regardless of G_nz.
  - 111 reserved: T1: Done only; no datapath effect.
- Latency from the Run-sample edge to Done: 1 cycle for mv/mvi/mvnz/111, 2 cycles for st, 3 cycles for add/sub/ld.
- Back-to-back: after Done, the next cycle is T0. With Run held at 1 the next instruction is captured at that T0 edge, so there are no idle cycles between instructions.
- Run toggling outside T0 is ignored.
- DIN changing outside T0 does not alter IR.

Test Plan:
- Reset then Run = 1 with DIN = 0x08A (add R1,R2) -> T0: IRin = 1; T1: Rout = 0x02, Ain = 1; T2: Rout = 0x04, Gin = 1, AddSub = 0; T3: Gout = 1, Rin = 0x02, Done = 1; next cycle step = 0.
- DIN = 0x058 (mvi R3), then DIN = 0x1FF during T1 -> T1: DINout = 1, Rin = 0x08, Done = 1; IR keeps 0x058.
- DIN = 0x165 (st R4,[R5]) -> T1: Rout = 0x20, ADDRin = 1; T2: Rout = 0x10, DOUTin = 1, W_D = 1, Done = 1; no T3.
- DIN = 0x181 (mvnz R0,R1) with G_nz = 0 -> T1: Rout = 0, Rin = 0, Done = 1. Repeat with G_nz = 1 -> Rout = 0x02, Rin = 0x01.
- DIN = 0x137 (ld R6,[R7]), assert Resetn in T2 -> next edge step = 0, IR = 0, no Rin pulse, no Done.
- Run held at 1 with DIN alternating mv/add -> Done is followed immediately by IRin in the next cycle; no Done outside final steps; Run = 0 holds step = 0 indefinitely.
